// File: rtl/dbus_arb_pkg.sv
// Shared types for the data-bus arbiter: FSM states, read-tag record, owner codes, saturating helpers.
package dbus_arb_pkg;

  typedef enum logic {
    PRI_M0   = 1'b0,
    FORCE_M1 = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam int WAIT_W = 4;

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v,
                                                     input logic [WAIT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dbus_rd_tag_pipe.sv
// Shift register of read tags, DEPTH cycles from issue to exit, aligned with RAM read latency.
// No backpressure: one tag enters and one leaves every cycle.
module dbus_rd_tag_pipe
  import dbus_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    core_clk_i,
  input  logic    arst_n_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t tag_q [DEPTH];
  rd_tag_t tag_d [DEPTH];

  always_comb begin
    tag_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge core_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master RAM arbiter: same-cycle grant, read data returned RAM_LATENCY later to the issuer; losers stall by holding req.
// m0 has priority, m1 is forced through after MAX_WAIT refusals. DBUS_ARB_STATS_EN adds conflict/forced counters.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  clock_50,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef DBUS_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           stat_conflicts,
  output logic [31:0]           stat_forced
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  rd_tag_t           tag_in, tag_out;

  // Grants are combinational; they are suppressed while reset is asserted so no access leaks out.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    state_d    = state_q;
    wait_cnt_d = '0;
    if (reset_n) begin
      unique case (state_q)
        PRI_M0: begin
          m0_gnt = m0_req;
          m1_gnt = m1_req && !m0_req;
        end
        FORCE_M1: begin
          m1_gnt = m1_req;
          m0_gnt = m0_req && !m1_req;
        end
        default: begin
          m0_gnt = 1'b0;
          m1_gnt = 1'b0;
        end
      endcase
    end

    if (m1_req && !m1_gnt) begin
      wait_cnt_d = sat_inc_wait(wait_cnt_q, MAX_WAIT_C);
    end

    unique case (state_q)
      PRI_M0:   if (wait_cnt_d == MAX_WAIT_C) state_d = FORCE_M1;
      FORCE_M1: state_d = PRI_M0;
      default:  state_d = PRI_M0;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PRI_M0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  always_comb begin
    tag_in.valid = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    tag_in.owner = m1_gnt ? OWNER_M1 : OWNER_M0;
  end

  dbus_rd_tag_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rd_tag_pipe (
    .core_clk_i (clock_50),
    .arst_n_i   (reset_n),
    .tag_i      (tag_in),
    .tag_o      (tag_out)
  );

  assign m0_rvalid = tag_out.valid && (tag_out.owner == OWNER_M0);
  assign m1_rvalid = tag_out.valid && (tag_out.owner == OWNER_M1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

`ifdef DBUS_ARB_STATS_EN
  logic [31:0] conflicts_q, forced_q;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      conflicts_q <= '0;
      forced_q    <= '0;
    end else if (stats_clr) begin
      conflicts_q <= '0;
      forced_q    <= '0;
    end else begin
      if (m0_req && m1_req) conflicts_q <= sat_inc32(conflicts_q);
      if ((state_q == FORCE_M1) && m1_gnt) forced_q <= sat_inc32(forced_q);
    end
  end

  assign stat_conflicts = conflicts_q;
  assign stat_forced    = forced_q;
`endif

endmodule
